// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD x5 multiplier: digit geometry,
// controller state encoding and a digit-validity helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_x5_state_t;

    // A digit above 9 is not BCD; it is still multiplied but flagged.
    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] dig);
        return (dig > BCD_MAX);
    endfunction

endpackage

// File: rtl/mul5bcd.sv
// Single-digit x5 in BCD: 5*i = 10*d + u with d = i>>1 and u = 5*i[0].
module mul5bcd
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i,
    output logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] u
);

    // Tens part and units part of the digit product.
    always_comb begin
        d = {1'b0, i[DIGIT_W-1:1]};
        u = i[0] ? 4'd5 : 4'd0;
    end

endmodule

// File: rtl/bcd_x5_serial.sv
// Serial BCD x5 controller: one operand digit per clock through a shared
// mul5bcd, with start/busy/done handshake and a registered product.
module bcd_x5_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        start,
    input  logic [DIGIT_W*NDIG-1:0]     a,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*(NDIG+1)-1:0] p,
    output logic                        err
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    bcd_x5_state_t                 state_r, state_s;
    logic [DIGIT_W*NDIG-1:0]       opnd_r, opnd_s;
    logic [IDX_W-1:0]              idx_r, idx_s;
    logic [DIGIT_W-1:0]            prev_d_r, prev_d_s;
    logic [DIGIT_W*(NDIG+1)-1:0]   p_r, p_s;
    logic                          err_r, err_s;
    logic                          busy_r, done_r;
    logic [DIGIT_W-1:0]            dig_s, d_s, u_s;

    // Operand digit mux feeding the shared digit multiplier.
    always_comb begin
        dig_s = opnd_r[int'(idx_r)*DIGIT_W +: DIGIT_W];
    end

    mul5bcd u_mul5bcd (
        .i (dig_s),
        .d (d_s),
        .u (u_s)
    );

    // Next-state and datapath update; no inter-digit carry since u+d <= 9.
    always_comb begin
        state_s  = state_r;
        opnd_s   = opnd_r;
        idx_s    = idx_r;
        prev_d_s = prev_d_r;
        p_s      = p_r;
        err_s    = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    opnd_s   = a;
                    idx_s    = '0;
                    prev_d_s = '0;
                    p_s      = '0;
                    err_s    = 1'b0;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                p_s[int'(idx_r)*DIGIT_W +: DIGIT_W] = u_s + prev_d_r;
                prev_d_s = d_s;
                err_s    = err_r | digit_invalid(dig_s);
                if (idx_r == IDX_LAST) begin
                    p_s[NDIG*DIGIT_W +: DIGIT_W] = d_s;
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r + IDX_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; busy/done decoded from next state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r  <= IDLE;
            opnd_r   <= '0;
            idx_r    <= '0;
            prev_d_r <= '0;
            p_r      <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            opnd_r   <= opnd_s;
            idx_r    <= idx_s;
            prev_d_r <= prev_d_s;
            p_r      <= p_s;
            err_r    <= err_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_x5_serial.sv
// Directed bench for bcd_x5_serial (NDIG=4) with hand-computed products.
module tb_bcd_x5_serial;

    localparam int NDIG = 4;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic [15:0] a;
    logic        busy;
    logic        done;
    logic [19:0] p;
    logic        err;

    int n_asrt = 0;
    int n_fail = 0;

    bcd_x5_serial #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation; optionally re-pulse start with another operand at E2.
    task automatic run_op(input logic [15:0] av, input logic [19:0] ep,
                          input logic ee, input string tag, input bit reissue);
        int dones;
        dones = 0;
        a = av;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy@E0"}, 32'(busy), 32'd1);
        chk({tag, " done@E0"}, 32'(done), 32'd0);
        for (int k = 1; k <= NDIG + 3; k++) begin
            if (reissue && k == 2) begin
                start = 1'b1;
                a = 16'h5555;
            end
            tick();
            if (reissue && k == 2) begin
                start = 1'b0;
            end
            if (done) dones++;
            if (k < NDIG) begin
                chk({tag, " busy run"}, 32'(busy), 32'd1);
            end else if (k == NDIG) begin
                chk({tag, " done"}, 32'(done), 32'd1);
                chk({tag, " busy done"}, 32'(busy), 32'd1);
                chk({tag, " p"}, 32'(p), 32'(ep));
                chk({tag, " err"}, 32'(err), 32'(ee));
            end else begin
                chk({tag, " busy idle"}, 32'(busy), 32'd0);
                chk({tag, " p hold"}, 32'(p), 32'(ep));
            end
        end
        chk({tag, " done count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        a = 16'h0000;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset p", 32'(p), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        run_op(16'h1234, 20'h06170, 1'b0, "op1234", 1'b0);
        run_op(16'h9999, 20'h49995, 1'b0, "op9999", 1'b0);
        run_op(16'h0000, 20'h00000, 1'b0, "op0000", 1'b0);
        run_op(16'h1234, 20'h06170, 1'b0, "ignored start", 1'b1);

        // IDLE holds result while the operand bus changes.
        a = 16'h7777;
        tick();
        tick();
        chk("idle hold p", 32'(p), 32'h06170);
        chk("idle hold busy", 32'(busy), 32'd0);

        // Abort mid-run with an asynchronous reset between E2 and E3.
        a = 16'h12A4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre-reset p", 32'(p), 32'h00020);
        chk("pre-reset err", 32'(err), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        chk("async rst err", 32'(err), 32'd0);
        chk("async rst p", 32'(p), 32'd0);
        #2;
        rst_b = 1'b1;
        tick();
        chk("post-reset busy", 32'(busy), 32'd0);

        run_op(16'h0001, 20'h00005, 1'b0, "op0001", 1'b0);
        run_op(16'h00A0, 20'h00500, 1'b1, "op00A0", 1'b0);
        run_op(16'h0002, 20'h00010, 1'b0, "op0002", 1'b0);

        // Start held high: an operation accepted every NDIG+2 cycles.
        a = 16'h0008;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 18; c++) begin
            tick();
            chk($sformatf("b2b done c%0d", c), 32'(done), 32'((c % 6) == 4));
            if ((c % 6) == 4) begin
                chk($sformatf("b2b p c%0d", c), 32'(p), 32'h00040);
            end
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk("final busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
